// File: rtl/doorlock_pkg.sv
// Purpose: shared state encoding and default timing constants for the door-lock sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package doorlock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_UNLOCK  = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_e;

    localparam int OPEN_CYC_DEF = 20;  // unlock hold after door closed / never opened
    localparam int LOCK_CYC_DEF = 50;  // lockout duration
    localparam int BEEP_CYC_DEF = 4;   // alarm beep on a non-final failure
    localparam int MAX_FAIL_DEF = 3;   // consecutive failures before lockout (1..7)
    localparam int TMR_W_DEF    = 16;  // shared down-counter width

endpackage

// File: rtl/dl_down_timer.sv
// Purpose: loadable down-counter that stops at zero and flags when it is there.
// Latency: load/decrement visible one cycle after the edge that samples them.
// Backpressure: none; load wins over enable, enable at zero holds zero.
//
// Ports: clk/rst (sync, active-high), load + load_val, en (decrement),
//        zero (current count is zero).
module dl_down_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/doorlock_access_ctrl.sv
// Purpose: sequences lock actuator, alarm and keypad enable from password-check pulses.
// Latency: all outputs registered, reflecting an input pulse one cycle later.
// Backpressure: none upstream; key_en low tells the core to stop taking keypad entry.
//
// Ports: clk, rst (sync, active-high); chk_ok/chk_fail/set_done one-cycle pulses from
//        the core; door_open sensor; unlock, alarm, key_en, lockout, fail_cnt[2:0] out.
module doorlock_access_ctrl
    import doorlock_pkg::*;
#(
    parameter int OPEN_CYC = OPEN_CYC_DEF,
    parameter int LOCK_CYC = LOCK_CYC_DEF,
    parameter int BEEP_CYC = BEEP_CYC_DEF,
    parameter int MAX_FAIL = MAX_FAIL_DEF,
    parameter int TMR_W    = TMR_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       chk_ok,
    input  logic       chk_fail,
    input  logic       set_done,
    input  logic       door_open,
    output logic       unlock,
    output logic       alarm,
    output logic       key_en,
    output logic       lockout,
    output logic [2:0] fail_cnt
);

    state_e      state_q, state_d;
    logic [2:0]  fail_cnt_q, fail_cnt_d;
    logic        unlock_q, unlock_d;
    logic        alarm_q, alarm_d;
    logic        key_en_q, key_en_d;
    logic        lockout_q, lockout_d;

    logic [3:0]       fail_inc;
    logic             tmr_load, tmr_en, tmr_zero;
    logic [TMR_W-1:0] tmr_val;
    logic             beep_load, beep_start, beep_zero;
    logic [TMR_W-1:0] beep_val;

    assign fail_inc = {1'b0, fail_cnt_q} + 4'd1;

    // The beep counter holds "remaining cycles - 1" while alarm_q is set, so the
    // registered alarm drops on the edge that finds the counter already at zero.
    assign beep_val = beep_start ? TMR_W'(BEEP_CYC - 1) : '0;

    always_comb begin
        state_d    = state_q;
        fail_cnt_d = fail_cnt_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        tmr_en     = 1'b0;
        beep_load  = 1'b0;
        beep_start = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // chk_fail outranks chk_ok, and any chk pulse outranks set_done.
                if (chk_fail) begin
                    if (fail_inc >= 4'(MAX_FAIL)) begin
                        state_d    = ST_LOCKOUT;
                        fail_cnt_d = 3'(MAX_FAIL);
                        tmr_load   = 1'b1;
                        tmr_val    = TMR_W'(LOCK_CYC - 1);
                        beep_load  = 1'b1;
                    end else begin
                        fail_cnt_d = fail_inc[2:0];
                        beep_load  = 1'b1;
                        beep_start = 1'b1;
                    end
                end else if (chk_ok) begin
                    state_d    = ST_UNLOCK;
                    fail_cnt_d = '0;
                    tmr_load   = 1'b1;
                    tmr_val    = TMR_W'(OPEN_CYC - 1);
                    beep_load  = 1'b1;
                end else if (set_done) begin
                    fail_cnt_d = '0;
                end
            end
            ST_UNLOCK: begin
                // An open door keeps re-arming the full hold window.
                if (door_open) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(OPEN_CYC - 1);
                end else if (tmr_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_LOCKOUT: begin
                if (tmr_zero) begin
                    state_d    = ST_IDLE;
                    fail_cnt_d = '0;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        unlock_d  = (state_d == ST_UNLOCK);
        lockout_d = (state_d == ST_LOCKOUT);
        key_en_d  = (state_d == ST_IDLE);
        alarm_d   = lockout_d || beep_start ||
                    ((state_q == ST_IDLE) && (state_d == ST_IDLE) && alarm_q && !beep_zero);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fail_cnt_q <= '0;
            unlock_q   <= 1'b0;
            alarm_q    <= 1'b0;
            key_en_q   <= 1'b1;
            lockout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fail_cnt_q <= fail_cnt_d;
            unlock_q   <= unlock_d;
            alarm_q    <= alarm_d;
            key_en_q   <= key_en_d;
            lockout_q  <= lockout_d;
        end
    end

    dl_down_timer #(.W(TMR_W)) u_main_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    dl_down_timer #(.W(TMR_W)) u_beep_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (beep_load),
        .load_val (beep_val),
        .en       (1'b1),
        .zero     (beep_zero)
    );

    assign unlock   = unlock_q;
    assign alarm    = alarm_q;
    assign key_en   = key_en_q;
    assign lockout  = lockout_q;
    assign fail_cnt = fail_cnt_q;

endmodule
